// File: rtl/gmii_tx_sched_pkg.sv
// Shared definitions for the GMII transmit scheduler and its framer.
// Contents: scheduler state encoding, packet type codes, default audio
// block size, packet length width, and the audio length helper.
package gmii_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PAY  = 2'd2,
    ST_WAIT = 2'd3
  } sched_state_t;

  localparam logic PKT_VIDEO = 1'b0;
  localparam logic PKT_AUDIO = 1'b1;

  localparam int unsigned ABLK_WORDS_DEF = 32;
  localparam int unsigned LEN_W          = 10;

  // Audio payload length in words; 15 blocks of 32 words still fits in 10 bits.
  function automatic logic [LEN_W-1:0] audio_len(input logic [3:0] blocks,
                                                 input int unsigned blk_words);
    return LEN_W'(blocks) * LEN_W'(blk_words);
  endfunction

endpackage

// File: rtl/gmii_tx_sched_stats.sv
// Saturating statistics counters for the GMII transmit scheduler.
// Only instantiated when GMII_SCHED_STATS_EN is defined.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   inc_v/inc_a  one-cycle strobes on video / audio packet acknowledge
//   inc_u        one-cycle strobe per underrun payload word
//   stat_*       counter values; each holds at all-ones once reached
module gmii_sched_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_v,
  input  logic        inc_a,
  input  logic        inc_u,
  output logic [31:0] stat_vpkts,
  output logic [31:0] stat_apkts,
  output logic [15:0] stat_urun
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_vpkts <= '0;
      stat_apkts <= '0;
      stat_urun  <= '0;
    end else begin
      if (inc_v && stat_vpkts != '1) stat_vpkts <= stat_vpkts + 32'd1;
      if (inc_a && stat_apkts != '1) stat_apkts <= stat_apkts + 32'd1;
      if (inc_u && stat_urun  != '1) stat_urun  <= stat_urun + 16'd1;
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII transmit scheduler: picks one packet at a time from the video FIFO
// (48-bit words) or the audio FIFO (24-bit words), hands type/length/sequence
// to the framer, and routes the framer's payload strobe to the chosen FIFO.
// Audio requests (adesig rising edge) win over video at IDLE; packets are
// never preempted.
// Optional feature: define GMII_SCHED_STATS_EN to add saturating counters
// stat_vpkts, stat_apkts, stat_urun.
// Ports:
//   tx_clk, sys_rst        clock, synchronous active-high reset
//   v_level, v_empty       video FIFO occupancy / empty
//   a_empty                audio FIFO empty
//   adesig, ade_num        audio window and ADE block count
//   pkt_req/type/len/seq   packet request to framer (held until pkt_ack)
//   pkt_ack, pkt_end       framer handshakes
//   pay_rd, pay_last       payload word strobe / final-word flag
//   v_rd_en, a_rd_en       FIFO read enables
//   underrun, a_overrun    sticky error flags
module gmii_tx_sched
  import gmii_tx_sched_pkg::*;
#(
  parameter int unsigned VID_WORDS  = 200,
  parameter int unsigned ABLK_WORDS = ABLK_WORDS_DEF,
  parameter int unsigned LVL_W      = 12
) (
  input  logic             tx_clk,
  input  logic             sys_rst,
  input  logic [LVL_W-1:0] v_level,
  input  logic             v_empty,
  input  logic             a_empty,
  input  logic             adesig,
  input  logic [3:0]       ade_num,
  output logic             pkt_req,
  output logic             pkt_type,
  output logic [LEN_W-1:0] pkt_len,
  output logic [15:0]      pkt_seq,
  input  logic             pkt_ack,
  input  logic             pay_rd,
  output logic             pay_last,
  input  logic             pkt_end,
  output logic             v_rd_en,
  output logic             a_rd_en,
  output logic             underrun,
  output logic             a_overrun
`ifdef GMII_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_vpkts,
  output logic [31:0]      stat_apkts,
  output logic [15:0]      stat_urun
`endif
);

  sched_state_t     state;
  logic             adesig_d;
  logic             a_pend;
  logic [LEN_W-1:0] a_len;
  logic [LEN_W-1:0] wcnt;
  logic [15:0]      v_seq;
  logic [15:0]      a_seq;

  logic a_req_new;
  logic ack_v;
  logic ack_a;
  logic pay_act;
  logic last_word;
  logic urun_word;

  always_comb begin
    a_req_new = adesig & ~adesig_d & (ade_num != '0);
    ack_v     = (state == ST_REQ) & pkt_ack & (pkt_type == PKT_VIDEO);
    ack_a     = (state == ST_REQ) & pkt_ack & (pkt_type == PKT_AUDIO);
    // Reset gates the strobe path directly so rd_en drops in the reset cycle.
    pay_act   = (state == ST_PAY) & pay_rd & ~sys_rst;
    last_word = (wcnt == pkt_len - LEN_W'(1));
    pay_last  = pay_act & last_word;
    v_rd_en   = pay_act & (pkt_type == PKT_VIDEO) & ~v_empty;
    a_rd_en   = pay_act & (pkt_type == PKT_AUDIO) & ~a_empty;
    urun_word = pay_act & ((pkt_type == PKT_AUDIO) ? a_empty : v_empty);
  end

  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      adesig_d  <= 1'b0;
      a_pend    <= 1'b0;
      a_len     <= '0;
      wcnt      <= '0;
      v_seq     <= '0;
      a_seq     <= '0;
      pkt_req   <= 1'b0;
      pkt_type  <= PKT_VIDEO;
      pkt_len   <= '0;
      pkt_seq   <= '0;
      underrun  <= 1'b0;
      a_overrun <= 1'b0;
    end else begin
      adesig_d <= adesig;
      if (urun_word) underrun <= 1'b1;

      // A new request in the ack cycle replaces the one being consumed,
      // so it is only an overrun when the old request is still unserved.
      if (a_req_new) begin
        a_pend <= 1'b1;
        a_len  <= audio_len(ade_num, ABLK_WORDS);
        if (a_pend && !ack_a) a_overrun <= 1'b1;
      end else if (ack_a) begin
        a_pend <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (a_pend) begin
            state    <= ST_REQ;
            pkt_req  <= 1'b1;
            pkt_type <= PKT_AUDIO;
            pkt_len  <= a_len;
            pkt_seq  <= a_seq;
          end else if (v_level >= LVL_W'(VID_WORDS)) begin
            state    <= ST_REQ;
            pkt_req  <= 1'b1;
            pkt_type <= PKT_VIDEO;
            pkt_len  <= LEN_W'(VID_WORDS);
            pkt_seq  <= v_seq;
          end
        end
        ST_REQ: begin
          if (pkt_ack) begin
            state   <= ST_PAY;
            pkt_req <= 1'b0;
            wcnt    <= '0;
          end
          if (ack_v) v_seq <= v_seq + 16'd1;
          if (ack_a) a_seq <= a_seq + 16'd1;
        end
        ST_PAY: begin
          if (pay_rd) begin
            if (last_word) state <= ST_WAIT;
            else           wcnt  <= wcnt + LEN_W'(1);
          end
        end
        ST_WAIT: begin
          if (pkt_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GMII_SCHED_STATS_EN
  gmii_sched_stats u_stats (
    .clk        (tx_clk),
    .rst        (sys_rst),
    .inc_v      (ack_v),
    .inc_a      (ack_a),
    .inc_u      (urun_word),
    .stat_vpkts (stat_vpkts),
    .stat_apkts (stat_apkts),
    .stat_urun  (stat_urun)
  );
`endif

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed testbench for gmii_tx_sched with a small framer driver.
module tb_gmii_tx_sched;

  logic        tx_clk = 1'b0;
  logic        sys_rst;
  logic [11:0] v_level;
  logic        v_empty;
  logic        a_empty;
  logic        adesig;
  logic [3:0]  ade_num;
  logic        pkt_req;
  logic        pkt_type;
  logic [9:0]  pkt_len;
  logic [15:0] pkt_seq;
  logic        pkt_ack;
  logic        pay_rd;
  logic        pay_last;
  logic        pkt_end;
  logic        v_rd_en;
  logic        a_rd_en;
  logic        underrun;
  logic        a_overrun;
`ifdef GMII_SCHED_STATS_EN
  logic [31:0] stat_vpkts;
  logic [31:0] stat_apkts;
  logic [15:0] stat_urun;
`endif

  int tests = 0;
  int fails = 0;

  always #5 tx_clk = ~tx_clk;

  gmii_tx_sched #(
    .VID_WORDS  (200),
    .ABLK_WORDS (32),
    .LVL_W      (12)
  ) dut (
    .tx_clk    (tx_clk),
    .sys_rst   (sys_rst),
    .v_level   (v_level),
    .v_empty   (v_empty),
    .a_empty   (a_empty),
    .adesig    (adesig),
    .ade_num   (ade_num),
    .pkt_req   (pkt_req),
    .pkt_type  (pkt_type),
    .pkt_len   (pkt_len),
    .pkt_seq   (pkt_seq),
    .pkt_ack   (pkt_ack),
    .pay_rd    (pay_rd),
    .pay_last  (pay_last),
    .pkt_end   (pkt_end),
    .v_rd_en   (v_rd_en),
    .a_rd_en   (a_rd_en),
    .underrun  (underrun),
    .a_overrun (a_overrun)
`ifdef GMII_SCHED_STATS_EN
    ,
    .stat_vpkts (stat_vpkts),
    .stat_apkts (stat_apkts),
    .stat_urun  (stat_urun)
`endif
  );

  // Framer stand-in: waits for a request, acks after ack_dly cycles, strobes
  // pay_rd until pay_last, idles an IFG, then pulses pkt_end. Reports what it saw.
  task automatic serve(input int ack_dly,
                       output logic typ, output logic [9:0] len, output logic [15:0] seq,
                       output int vcnt, output int acnt, output int nstr, output int lastpos,
                       output bit got, output bit done, output logic req_after_ack);
    typ = 1'b0; len = '0; seq = '0;
    vcnt = 0; acnt = 0; nstr = 0; lastpos = 0;
    got = 1'b0; done = 1'b0; req_after_ack = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge tx_clk);
      if (pkt_req === 1'b1) got = 1'b1;
    end
    if (!got) return;
    typ = pkt_type; len = pkt_len; seq = pkt_seq;
    repeat (ack_dly) @(negedge tx_clk);
    pkt_ack = 1'b1;
    @(negedge tx_clk);
    pkt_ack = 1'b0;
    req_after_ack = pkt_req;
    pay_rd = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      #1;
      if (v_rd_en === 1'b1) vcnt++;
      if (a_rd_en === 1'b1) acnt++;
      nstr++;
      if (pay_last === 1'b1) begin
        lastpos = nstr;
        done = 1'b1;
      end
      @(negedge tx_clk);
    end
    pay_rd = 1'b0;
    repeat (3) @(negedge tx_clk);
    pkt_end = 1'b1;
    @(negedge tx_clk);
    pkt_end = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; v_level = '0; v_empty = 1'b0; a_empty = 1'b0;
    adesig = 1'b0; ade_num = '0; pkt_ack = 1'b0; pay_rd = 1'b1; pkt_end = 1'b0;
    repeat (3) @(negedge tx_clk);
    #1;
    tests++;
    if ({pkt_req, pkt_type, pkt_len, pkt_seq, pay_last, v_rd_en, a_rd_en, underrun, a_overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b type=%b len=%0d seq=%0d last=%b vrd=%b ard=%b urun=%b aovr=%b, all required 0",
               pkt_req, pkt_type, pkt_len, pkt_seq, pay_last, v_rd_en, a_rd_en, underrun, a_overrun);
    end
    pay_rd = 1'b0;
    @(negedge tx_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_video;
    logic t; logic [9:0] l; logic [15:0] s; int vc, ac, ns, lp; bit g, d; logic ra;
    v_level = 12'd200;
    serve(2, t, l, s, vc, ac, ns, lp, g, d, ra);
    v_level = '0;
    tests++; if (g !== 1'b1) begin fails++; $display("FAIL video_req: got=%b required 1", g); end
    tests++; if (t !== 1'b0) begin fails++; $display("FAIL video_type: got=%b required 0", t); end
    tests++; if (l !== 10'd200) begin fails++; $display("FAIL video_len: got=%0d required 200", l); end
    tests++; if (s !== 16'd0) begin fails++; $display("FAIL video_seq: got=%0d required 0", s); end
    tests++; if (ra !== 1'b0) begin fails++; $display("FAIL video_req_drop: got=%b required 0", ra); end
    tests++; if (vc != 200) begin fails++; $display("FAIL video_rd_count: got=%0d required 200", vc); end
    tests++; if (ac != 0) begin fails++; $display("FAIL video_ard_count: got=%0d required 0", ac); end
    tests++; if (lp != 200) begin fails++; $display("FAIL video_last_pos: got=%0d required 200", lp); end
  endtask

  task automatic test_audio_defer;
    logic t; logic [9:0] l; logic [15:0] s; int vc, ac, ns, lp; bit g, d; logic ra;
    v_level = 12'd200;
    fork
      serve(2, t, l, s, vc, ac, ns, lp, g, d, ra);
      begin
        repeat (60) @(negedge tx_clk);
        adesig = 1'b1; ade_num = 4'd3;
        repeat (3) @(negedge tx_clk);
        adesig = 1'b0;
      end
    join
    v_level = '0;
    tests++; if (t !== 1'b0 || s !== 16'd1) begin fails++; $display("FAIL defer_video: type=%b seq=%0d required 0/1", t, s); end
    tests++; if (vc != 200 || lp != 200) begin fails++; $display("FAIL defer_video_complete: vrd=%0d last=%0d required 200/200", vc, lp); end
    serve(1, t, l, s, vc, ac, ns, lp, g, d, ra);
    tests++; if (g !== 1'b1 || t !== 1'b1) begin fails++; $display("FAIL audio_req: got=%b type=%b required 1/1", g, t); end
    tests++; if (l !== 10'd96) begin fails++; $display("FAIL audio_len: got=%0d required 96", l); end
    tests++; if (s !== 16'd0) begin fails++; $display("FAIL audio_seq: got=%0d required 0", s); end
    tests++; if (ac != 96 || vc != 0 || lp != 96) begin fails++; $display("FAIL audio_rd: ard=%0d vrd=%0d last=%0d required 96/0/96", ac, vc, lp); end
    tests++; if (a_overrun !== 1'b0) begin fails++; $display("FAIL audio_no_overrun: got=%b required 0", a_overrun); end
  endtask

  task automatic test_threshold;
    logic t; logic [9:0] l; logic [15:0] s; int vc, ac, ns, lp; bit g, d; logic ra;
    bit seen;
    v_level = 12'd199;
    repeat (6) @(negedge tx_clk);
    tests++; if (pkt_req !== 1'b0) begin fails++; $display("FAIL thresh_199: pkt_req=%b required 0", pkt_req); end
    v_level = 12'd200;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge tx_clk);
      if (pkt_req === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL thresh_200: pkt_req not high within 2 cycles, required 1"); end
    serve(0, t, l, s, vc, ac, ns, lp, g, d, ra);
    v_level = '0;
    tests++; if (t !== 1'b0 || s !== 16'd2 || vc != 200) begin fails++; $display("FAIL thresh_pkt: type=%b seq=%0d vrd=%0d required 0/2/200", t, s, vc); end
  endtask

  task automatic test_overrun;
    logic t; logic [9:0] l; logic [15:0] s; int vc, ac, ns, lp; bit g, d; logic ra;
    int extra;
    v_level = 12'd200;
    fork
      serve(2, t, l, s, vc, ac, ns, lp, g, d, ra);
      begin
        repeat (50) @(negedge tx_clk);
        adesig = 1'b1; ade_num = 4'd2;
        repeat (3) @(negedge tx_clk);
        adesig = 1'b0;
        repeat (5) @(negedge tx_clk);
        adesig = 1'b1; ade_num = 4'd5;
        repeat (3) @(negedge tx_clk);
        adesig = 1'b0;
      end
    join
    v_level = '0;
    tests++; if (s !== 16'd3 || vc != 200) begin fails++; $display("FAIL ovr_video: seq=%0d vrd=%0d required 3/200", s, vc); end
    tests++; if (a_overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got=%b required 1", a_overrun); end
    serve(1, t, l, s, vc, ac, ns, lp, g, d, ra);
    tests++; if (t !== 1'b1 || l !== 10'd160 || s !== 16'd1) begin fails++; $display("FAIL ovr_audio: type=%b len=%0d seq=%0d required 1/160/1", t, l, s); end
    tests++; if (ac != 160 || lp != 160) begin fails++; $display("FAIL ovr_audio_rd: ard=%0d last=%0d required 160/160", ac, lp); end
    extra = 0;
    repeat (20) begin
      @(negedge tx_clk);
      if (pkt_req === 1'b1) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL ovr_single: extra req cycles=%0d required 0", extra); end
  endtask

  task automatic test_underrun;
    logic t; logic [9:0] l; logic [15:0] s; int vc, ac, ns, lp; bit g, d; logic ra;
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL urun_pre: got=%b required 0", underrun); end
    a_empty = 1'b1;
    adesig = 1'b1; ade_num = 4'd1;
    @(negedge tx_clk);
    adesig = 1'b0;
    serve(1, t, l, s, vc, ac, ns, lp, g, d, ra);
    tests++; if (t !== 1'b1 || l !== 10'd32 || s !== 16'd2) begin fails++; $display("FAIL urun_pkt: type=%b len=%0d seq=%0d required 1/32/2", t, l, s); end
    tests++; if (ac != 0 || ns != 32 || lp != 32) begin fails++; $display("FAIL urun_rd: ard=%0d strobes=%0d last=%0d required 0/32/32", ac, ns, lp); end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL urun_flag: got=%b required 1", underrun); end
    a_empty = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic t; logic [9:0] l; logic [15:0] s; int vc, ac, ns, lp; bit g, d; logic ra;
    bit seen;
    v_level = 12'd200;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge tx_clk);
      if (pkt_req === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rst_mid_req: no pkt_req, required 1"); end
    pkt_ack = 1'b1;
    @(negedge tx_clk);
    pkt_ack = 1'b0;
    pay_rd = 1'b1;
    repeat (10) @(negedge tx_clk);
    #1;
    tests++; if (v_rd_en !== 1'b1) begin fails++; $display("FAIL rst_mid_pay: v_rd_en=%b required 1", v_rd_en); end
    @(negedge tx_clk);
    sys_rst = 1'b1;
    #1;
    tests++; if (v_rd_en !== 1'b0) begin fails++; $display("FAIL rst_mid_rden: v_rd_en=%b required 0", v_rd_en); end
    @(negedge tx_clk);
    tests++;
    if ({pkt_req, pkt_len, pkt_seq, pay_last, v_rd_en, a_rd_en, underrun, a_overrun} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: req=%b len=%0d seq=%0d last=%b vrd=%b ard=%b urun=%b aovr=%b, all required 0",
               pkt_req, pkt_len, pkt_seq, pay_last, v_rd_en, a_rd_en, underrun, a_overrun);
    end
    pay_rd = 1'b0;
    sys_rst = 1'b0;
    serve(1, t, l, s, vc, ac, ns, lp, g, d, ra);
    v_level = '0;
    tests++; if (g !== 1'b1 || t !== 1'b0 || s !== 16'd0 || l !== 10'd200) begin fails++; $display("FAIL rst_mid_next: got=%b type=%b seq=%0d len=%0d required 1/0/0/200", g, t, s, l); end
    tests++; if (vc != 200) begin fails++; $display("FAIL rst_mid_next_rd: vrd=%0d required 200", vc); end
  endtask

  initial begin
    test_reset();
    test_video();
    test_audio_defer();
    test_threshold();
    test_overrun();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
